// File: rtl/bk_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ requesters.
// The winner's byte is latched at grant, handed over with ready/busy, and acknowledged.
module bk_uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int GAP_CYC     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ack_o,
  output logic               req_err_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               arb_busy_o,
  output logic [7:0]         uart_data_o,
  output logic               uart_ready_o,
  input  logic               uart_busy_i,
  output logic [2:0]         dbg_state
);

  // Handshake: uart_ready_o offers uart_data_o; the transmitter takes it by raising
  // uart_busy_i, which drops ready at once, and finishes the byte by lowering busy.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_SEND = 3'd2,
    S_DONE = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic [ID_W-1:0]   rr_next;
  logic [N_REQ-1:0]  grant_onehot;

  assign dbg_state = state;

  // First pending requester at or after the round-robin pointer, wrapping.
  always_comb begin
    win_id    = rr_ptr;
    win_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req_valid_i[(int'(rr_ptr) + i) % N_REQ]) begin
        win_id    = ID_W'((int'(rr_ptr) + i) % N_REQ);
        win_found = 1'b1;
      end
    end
  end

  assign rr_next      = (grant_id_o == ID_W'(N_REQ - 1)) ? '0 : grant_id_o + ID_W'(1);
  assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      cnt          <= '0;
      req_ack_o    <= '0;
      req_err_o    <= 1'b0;
      grant_id_o   <= '0;
      arb_busy_o   <= 1'b0;
      uart_data_o  <= '0;
      uart_ready_o <= 1'b0;
    end else begin
      req_ack_o <= '0;
      req_err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            uart_data_o  <= req_data_i[8*win_id +: 8];
            grant_id_o   <= win_id;
            uart_ready_o <= 1'b1;
            arb_busy_o   <= 1'b1;
            cnt          <= CNT_W'(1);
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          // Busy is tested first so an acceptance on the last allowed cycle is not an error.
          if (uart_busy_i) begin
            uart_ready_o <= 1'b0;
            state        <= S_SEND;
          end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
            uart_ready_o <= 1'b0;
            req_ack_o    <= grant_onehot;
            req_err_o    <= 1'b1;
            state        <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SEND: begin
          if (!uart_busy_i) begin
            req_ack_o <= grant_onehot;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          rr_ptr <= rr_next;
          cnt    <= CNT_W'(1);
          state  <= S_GAP;
        end
        S_GAP: begin
          if (cnt == CNT_W'(GAP_CYC)) begin
            arb_busy_o <= 1'b0;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          uart_ready_o <= 1'b0;
          arb_busy_o   <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bk_uart_tx_arbiter.sv
// Bench for bk_uart_tx_arbiter: directed requester traffic, a transmitter model,
// and an ack monitor that pops expected {id, err, byte} entries in grant order.
module tb_bk_uart_tx_arbiter;

  localparam int N_REQ       = 4;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int GAP_CYC     = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]   req_valid = '0;
  logic [8*N_REQ-1:0] req_data  = '0;
  logic [N_REQ-1:0]   req_ack;
  logic               req_err;
  logic [ID_W-1:0]    grant_id;
  logic               arb_busy;
  logic [7:0]         uart_data;
  logic               uart_ready;
  logic               uart_busy = 1'b0;
  logic [2:0]         dbg_state;

  bk_uart_tx_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ack_o(req_ack), .req_err_o(req_err), .grant_id_o(grant_id),
    .arb_busy_o(arb_busy), .uart_data_o(uart_data), .uart_ready_o(uart_ready),
    .uart_busy_i(uart_busy), .dbg_state(dbg_state)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [10:0] exp_q[$];   // {id[1:0], err, data[7:0]}

  int         rem[N_REQ];
  logic [7:0] dbyte[N_REQ];
  logic       uart_en   = 1'b1;
  int         rise_dly  = 2;
  int         hold_len  = 5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic err, input logic [7:0] d);
    exp_q.push_back({2'(id), err, d});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   32'(req_ack),    0);
    check({tag, "_err"},   32'(req_err),    0);
    check({tag, "_grant"}, 32'(grant_id),   0);
    check({tag, "_busy"},  32'(arb_busy),   0);
    check({tag, "_data"},  32'(uart_data),  0);
    check({tag, "_ready"}, 32'(uart_ready), 0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_drain: %0d acks outstanding after %0d cycles, expected 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n = 0;
    while (!uart_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_seen"}, 32'(uart_busy), 1);
  endtask

  // requester driver: valid holds while bytes remain, one byte retired per ack
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_ack[k] && rem[k] > 0) rem[k]--;
      req_valid[k]      = (rem[k] > 0);
      req_data[8*k +: 8] = dbyte[k];
    end
  end

  // transmitter model: busy rises rise_dly cycles after ready, lasts hold_len cycles
  initial begin
    forever begin
      @(negedge clk);
      if (uart_en && uart_ready && rst_n) begin
        repeat (rise_dly - 1) @(negedge clk);
        uart_busy = 1'b1;
        for (int j = 0; j < hold_len && rst_n; j++) @(negedge clk);
        uart_busy = 1'b0;
      end
    end
  end

  // monitor: ready span / gap tracking and ack scoreboard
  int         hi_len = 0, lo_len = 0, last_span = 0, ack_idx;
  bit         seen_fall = 0;
  logic [N_REQ-1:0] prev_ack = '0;
  logic       prev_ready = 1'b0;
  logic [10:0] e;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      hi_len = 0; lo_len = 0; seen_fall = 0; prev_ack = '0; prev_ready = 1'b0;
    end else begin
      if (uart_ready) begin
        if (!prev_ready && seen_fall) begin
          compared++;
          if (lo_len < GAP_CYC) begin
            mismatched++;
            $display("FAIL ready_gap: got %0d idle cycles required >= %0d", lo_len, GAP_CYC);
          end
        end
        hi_len++;
      end else begin
        if (prev_ready) begin
          last_span = hi_len; hi_len = 0; seen_fall = 1; lo_len = 0;
        end
        lo_len++;
      end
      if (req_ack != '0) begin
        check("ack_onehot", 32'($countones(req_ack)), 1);
        check("ack_one_cycle", 32'(prev_ack), 0);
        ack_idx = 0;
        for (int k = 0; k < N_REQ; k++) if (req_ack[k]) ack_idx = k;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL stray_ack: got ack %b required none", req_ack);
        end else begin
          e = exp_q.pop_front();
          check("ack_id",   32'(ack_idx),   32'(e[10:9]));
          check("ack_err",  32'(req_err),   32'(e[8]));
          check("ack_data", 32'(uart_data), 32'(e[7:0]));
        end
      end else if (req_err) begin
        check("err_without_ack", 32'(req_err), 0);
      end
      prev_ack   = req_ack;
      prev_ready = uart_ready;
    end
  end

  initial begin
    for (int k = 0; k < N_REQ; k++) begin
      rem[k] = 0;
      dbyte[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // all four requesting continuously, two bytes each: 0,1,2,3,0,1,2,3
    dbyte[0] = 8'h11; dbyte[1] = 8'h22; dbyte[2] = 8'h33; dbyte[3] = 8'h44;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N_REQ; k++) push_exp(k, 1'b0, dbyte[k]);
    for (int k = 0; k < N_REQ; k++) rem[k] = 2;
    wait_drain("rr_all", 400);

    // single request with a long transmitter busy
    hold_len = 100;
    dbyte[2] = 8'hA5;
    push_exp(2, 1'b0, 8'hA5);
    rem[2] = 1;
    wait_drain("single", 300);
    check("single_ready_span", 32'(last_span), 2);

    // pointer now at 3: requesters 0 and 3 -> 3 first, then 0
    hold_len = 5;
    dbyte[0] = 8'hC0; dbyte[3] = 8'hD3;
    push_exp(3, 1'b0, 8'hD3);
    push_exp(0, 1'b0, 8'hC0);
    rem[0] = 1; rem[3] = 1;
    wait_drain("wrap", 200);

    // requester 3 changes its byte and drops valid while the byte is shifting
    hold_len = 20;
    dbyte[3] = 8'h5C;
    push_exp(3, 1'b0, 8'h5C);
    rem[3] = 1;
    wait_busy("drop", 50);
    @(negedge clk);
    dbyte[3] = 8'hFF;
    rem[3] = 0;
    wait_drain("drop", 100);

    // transmitter never accepts: ready spans TIMEOUT_CYC, ack with error
    uart_en = 1'b0;
    dbyte[1] = 8'hB1;
    push_exp(1, 1'b1, 8'hB1);
    rem[1] = 1;
    wait_drain("timeout", 100);
    check("timeout_ready_span", 32'(last_span), TIMEOUT_CYC);
    uart_en = 1'b1;

    // reset while sending: outputs clear at once, pointer restarts at 0
    hold_len = 50;
    dbyte[3] = 8'h3C;
    push_exp(3, 1'b0, 8'h3C);
    rem[3] = 1;
    wait_busy("rst", 50);
    repeat (3) @(negedge clk);
    dbyte[1] = 8'h1E;
    rem[1] = 1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    push_exp(1, 1'b0, 8'h1E);
    push_exp(3, 1'b0, 8'h3C);
    hold_len = 5;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_drain("after_rst", 200);

    // busy arrives on the same cycle the timeout count is reached: no error
    rise_dly = TIMEOUT_CYC;
    dbyte[0] = 8'hE7;
    push_exp(0, 1'b0, 8'hE7);
    rem[0] = 1;
    wait_drain("busy_wins", 100);
    check("busy_wins_ready_span", 32'(last_span), TIMEOUT_CYC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
